mdu: RTL and testbench
======================

Name: mdu

Overview:
- Multi-cycle multiply/divide unit in the EX stage, alongside the ALU; consumes the same forwarded srcA/srcB operands.
- Owns the architectural HI/LO registers and implements mult, multu, div, divu, mthi, mtlo, mfhi and mflo.
- Its out is muxed with the ALU result into the EX/MEM pipeline register.
- The hazard unit stalls ID while (start | busy) and an MDU instruction is in ID.

Parameters:
MULT_CYCLES  5   busy cycles for mult/multu (>=1)
DIV_CYCLES   10  busy cycles for div/divu (>=1)

Ports:
clk    input   1   clock, all state updates on rising edge
reset  input   1   synchronous, active-high; clears all state
srcA   input   32  operand rs (dividend / multiplicand / mthi-mtlo data)
srcB   input   32  operand rt (divisor / multiplier)
op     input   4   operation select, codes below
start  input   1   one-cycle pulse launching mult/multu/div/divu in op
busy   output  1   high while a mult/div is in flight
hi     output  32  HI register value
lo     output  32  LO register value
out    output  32  mfhi -> hi, mflo -> lo, otherwise 0 (combinational)

Behaviour:
- op codes:
  - 4'b0000 none
  - 4'b0001 mult
  - 4'b0010 multu
  - 4'b0011 div
  - 4'b0100 divu
  - 4'b0101 mthi
  - 4'b0110 mtlo
  - 4'b0111 mfhi
  - 4'b1000 mflo
  - other codes: treat as none
- Reset:
  - busy=0, hi=0, lo=0, internal counter=0, pending results discarded.
  - Reset mid-operation aborts it; no HI/LO write occurs.
- State:
  - IDLE / BUSY, tracked with a down-counter.
  - Results are held in internal temp registers until commit.
- Launch: at edge k with start=1, busy=0 and op in {mult, multu, div, divu}:
  - latch the result into the temp registers;
  - load the counter with N (MULT_CYCLES or DIV_CYCLES);
  - busy=1 for cycles k+1 .. k+N.
- Commit:
  - On the edge where the counter goes 1->0, write temp to HI/LO and drop busy on that same edge.
  - The new hi/lo are visible in the first cycle with busy=0.
- start rules:
  - start with op outside {mult, multu, div, divu} is ignored.
  - start while busy=1 is ignored; the in-flight operation is unaffected.
  - The pipeline guarantees this never happens; the bench checks it anyway.
- mthi/mtlo:
  - When op=mthi/mtlo and busy=0, hi/lo <= srcA at the next edge; start is not required.
  - Ignored while busy=1.
  - mthi/mtlo together with start in the same cycle: the launch wins and mthi/mtlo is dropped.
- mfhi/mflo:
  - out reflects the current hi/lo combinationally, with no forwarding of in-flight results.
  - The stall rule prevents mfhi/mflo from reaching EX while busy.
- Arithmetic:
  - mult: signed 32x32 -> 64; HI = [63:32], LO = [31:0].
  - multu: unsigned 32x32 -> 64; same HI/LO split.
  - div: signed; LO = quotient truncated toward zero, HI = remainder with the sign of the dividend.
  - divu: unsigned; LO = quotient, HI = remainder.
  - div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- Divide by zero (div/divu, srcB=0):
  - Full DIV_CYCLES busy period still runs.
  - HI/LO keep their previous values at commit.
- busy does not depend combinationally on start; it is a pure register output.

Test Plan:
- Signed mult: reset; srcA=0xFFFFFFFF, srcB=2, op=mult, start=1 for 1 cycle.
  - busy=1 for exactly 5 cycles.
  - Then hi=0xFFFFFFFF, lo=0xFFFFFFFE.
  - hi/lo stay 0 while busy.
- Unsigned mult: srcA=0xFFFFFFFF, srcB=2, op=multu, start=1.
  - After 5 busy cycles: hi=0x00000001, lo=0xFFFFFFFE.
- Signed div, including the overflow case:
  - srcA=0xFFFFFFF9 (-7), srcB=2, op=div, start=1: busy 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - Repeat with srcA=0x80000000, srcB=0xFFFFFFFF: lo=0x80000000, hi=0.
- Divide by zero: mthi 0x12345678, mtlo 0x9ABCDEF0; then divu srcA=7, srcB=0, start=1.
  - busy 10 cycles.
  - hi=0x12345678, lo=0x9ABCDEF0 unchanged.
  - op=mfhi gives out=0x12345678; op=mflo gives out=0x9ABCDEF0.
- Ignored requests: launch mult 3*4; at busy cycle 2 pulse start with div 100/7, and assert op=mtlo with srcA=0xDEAD.
  - Both are ignored.
  - busy ends after 5 cycles total.
  - hi=0, lo=12.
- Reset mid-operation: launch div 100/7; assert reset at busy cycle 4.
  - Next cycle: busy=0, hi=0, lo=0.
  - No late commit occurs over the following 10 cycles.

Source files
------------

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit owning the architectural HI/LO registers.
// Results are computed at launch, held in temp registers and committed when the busy countdown expires.
module mdu #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] srcA,
    input  logic [31:0] srcB,
    input  logic [3:0]  op,
    input  logic        start,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] out
);

    localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CW      = $clog2(MAX_CYC + 1);

    localparam logic [3:0] OP_MULT  = 4'b0001;
    localparam logic [3:0] OP_MULTU = 4'b0010;
    localparam logic [3:0] OP_DIV   = 4'b0011;
    localparam logic [3:0] OP_DIVU  = 4'b0100;
    localparam logic [3:0] OP_MTHI  = 4'b0101;
    localparam logic [3:0] OP_MTLO  = 4'b0110;
    localparam logic [3:0] OP_MFHI  = 4'b0111;
    localparam logic [3:0] OP_MFLO  = 4'b1000;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   hi_q, hi_d, lo_q, lo_d;
    logic [31:0]   tmp_hi_q, tmp_hi_d, tmp_lo_q, tmp_lo_d;
    logic          skip_q, skip_d;

    logic        is_mul, is_div, launch;
    logic [63:0] prod_s, prod_u;
    logic [31:0] abs_a, abs_b, div_s_b, div_u_b;
    logic [31:0] quo_mag, rem_mag, quo_s, rem_s;
    logic [31:0] res_hi, res_lo;

    assign is_mul = (op == OP_MULT) || (op == OP_MULTU);
    assign is_div = (op == OP_DIV)  || (op == OP_DIVU);
    assign launch = start && (is_mul || is_div);

    // Operand arithmetic; divisors forced to 1 on zero so the result is defined (it is discarded anyway)
    always_comb begin
        prod_s  = {{32{srcA[31]}}, srcA} * {{32{srcB[31]}}, srcB};
        prod_u  = {32'b0, srcA} * {32'b0, srcB};
        abs_a   = srcA[31] ? 32'(-srcA) : srcA;
        abs_b   = srcB[31] ? 32'(-srcB) : srcB;
        div_s_b = (abs_b == 32'd0) ? 32'd1 : abs_b;
        div_u_b = (srcB == 32'd0) ? 32'd1 : srcB;
        quo_mag = abs_a / div_s_b;
        rem_mag = abs_a % div_s_b;
        quo_s   = (srcA[31] ^ srcB[31]) ? 32'(-quo_mag) : quo_mag;
        rem_s   = srcA[31] ? 32'(-rem_mag) : rem_mag;
    end

    always_comb begin
        res_hi = 32'd0;
        res_lo = 32'd0;
        case (op)
            OP_MULT:  {res_hi, res_lo} = prod_s;
            OP_MULTU: {res_hi, res_lo} = prod_u;
            OP_DIV: begin
                res_hi = rem_s;
                res_lo = quo_s;
            end
            OP_DIVU: begin
                res_hi = srcA % div_u_b;
                res_lo = srcA / div_u_b;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            tmp_hi_q <= '0;
            tmp_lo_q <= '0;
            skip_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            tmp_hi_q <= tmp_hi_d;
            tmp_lo_q <= tmp_lo_d;
            skip_q   <= skip_d;
        end
    end

    // Launch/countdown/commit; mthi/mtlo only land while idle and not launching
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        tmp_hi_d = tmp_hi_q;
        tmp_lo_d = tmp_lo_q;
        skip_d   = skip_q;
        case (state_q)
            IDLE: begin
                if (launch) begin
                    state_d  = BUSY;
                    cnt_d    = is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                    tmp_hi_d = res_hi;
                    tmp_lo_d = res_lo;
                    skip_d   = is_div && (srcB == 32'd0);
                end else if (op == OP_MTHI) begin
                    hi_d = srcA;
                end else if (op == OP_MTLO) begin
                    lo_d = srcA;
                end
            end
            default: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = IDLE;
                    if (!skip_q) begin
                        hi_d = tmp_hi_q;
                        lo_d = tmp_lo_q;
                    end
                end
            end
        endcase
    end

    assign busy = (state_q == BUSY);
    assign hi   = hi_q;
    assign lo   = lo_q;

    always_comb begin
        out = 32'd0;
        if (op == OP_MFHI)
            out = hi_q;
        else if (op == OP_MFLO)
            out = lo_q;
    end

endmodule

// File: tb/tb_mdu.sv
// Scoreboard bench for mdu: stimulus pushes the expected commit, a negedge monitor checks each busy window.
module tb_mdu;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] srcA = '0;
    logic [31:0] srcB = '0;
    logic [3:0]  op = '0;
    logic        start = 1'b0;
    logic        busy;
    logic [31:0] hi, lo, out;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       name;
        int          cycles;
        logic [31:0] hi;
        logic [31:0] lo;
        logic [31:0] old_hi;
        logic [31:0] old_lo;
    } exp_t;

    exp_t exp_q[$];

    mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .srcA(srcA), .srcB(srcB), .op(op),
        .start(start), .busy(busy), .hi(hi), .lo(lo), .out(out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, expv);
        end
    endtask

    // Monitor: hi/lo frozen during busy, then length and committed values on busy fall
    int  run_len = 0;
    bit  was_busy = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (busy) begin
            run_len++;
            if (exp_q.size() == 0) begin
                check("unexpected_busy", 64'(busy), 64'(0));
            end else begin
                e = exp_q[0];
                check({e.name, "_hold"}, {hi, lo}, {e.old_hi, e.old_lo});
            end
        end else if (was_busy) begin
            if (exp_q.size() == 0) begin
                check("unexpected_end", 64'(1), 64'(0));
            end else begin
                e = exp_q.pop_front();
                check({e.name, "_len"}, 64'(run_len), 64'(e.cycles));
                check({e.name, "_hilo"}, {hi, lo}, {e.hi, e.lo});
            end
        end
        was_busy = busy;
        if (!busy) run_len = 0;
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycle();
        cycle();
        reset = 1'b0;
    endtask

    task automatic push(input string name, input int n, input logic [31:0] h, input logic [31:0] l);
        exp_t e;
        e.name = name; e.cycles = n; e.hi = h; e.lo = l; e.old_hi = hi; e.old_lo = lo;
        exp_q.push_back(e);
    endtask

    task automatic launch(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        op = o; srcA = a; srcB = b; start = 1'b1;
        cycle();
        start = 1'b0; op = 4'd0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 40) begin
            cycle();
            n++;
        end
        if (busy) check({name, "_timeout"}, 64'(busy), 64'(0));
        cycle();
    endtask

    task automatic run(input string name, input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                       input int n, input logic [31:0] h, input logic [31:0] l);
        push(name, n, h, l);
        launch(o, a, b);
        wait_idle(name);
    endtask

    initial begin
        do_reset();
        check("reset_state", {31'd0, busy, hi}, {31'd0, 1'b0, 32'd0});
        check("reset_lo_out", {lo, out}, 64'd0);

        // start with a non-launch op while idle does nothing
        op = 4'd0; start = 1'b1;
        cycle();
        start = 1'b0;
        cycle();
        check("start_none", {31'd0, busy, hi}, 64'd0);

        run("mult_neg",  4'd1, 32'hFFFFFFFF, 32'd2, 5, 32'hFFFFFFFF, 32'hFFFFFFFE);
        run("multu",     4'd2, 32'hFFFFFFFF, 32'd2, 5, 32'h00000001, 32'hFFFFFFFE);
        run("mult_nn",   4'd1, 32'hFFFFFFFD, 32'hFFFFFFFC, 5, 32'd0, 32'd12);
        run("div_neg",   4'd3, 32'hFFFFFFF9, 32'd2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run("div_ovf",   4'd3, 32'h80000000, 32'hFFFFFFFF, 10, 32'd0, 32'h80000000);
        run("div_negb",  4'd3, 32'd7, 32'hFFFFFFFE, 10, 32'd1, 32'hFFFFFFFD);
        run("divu",      4'd4, 32'd100, 32'd7, 10, 32'd2, 32'd14);

        op = 4'd5; srcA = 32'h12345678;
        cycle();
        op = 4'd6; srcA = 32'h9ABCDEF0;
        cycle();
        op = 4'd0;
        check("mthi_mtlo", {hi, lo}, {32'h12345678, 32'h9ABCDEF0});
        run("divu_zero", 4'd4, 32'd7, 32'd0, 10, 32'h12345678, 32'h9ABCDEF0);
        op = 4'd7;
        #1 check("mfhi", 64'(out), 64'(32'h12345678));
        op = 4'd8;
        #1 check("mflo", 64'(out), 64'(32'h9ABCDEF0));
        op = 4'd0;
        #1 check("out_none", 64'(out), 64'd0);

        // Requests while busy are dropped
        do_reset();
        push("ignored", 5, 32'd0, 32'd12);
        launch(4'd1, 32'd3, 32'd4);
        op = 4'd3; srcA = 32'd100; srcB = 32'd7; start = 1'b1;
        cycle();
        start = 1'b0; op = 4'd6; srcA = 32'h0000DEAD;
        cycle();
        op = 4'd0;
        wait_idle("ignored");
        cycle();
        check("ignored_idle", {31'd0, busy, lo}, {31'd0, 1'b0, 32'd12});

        // Reset mid-divide aborts without commit
        do_reset();
        push("abort", 4, 32'd0, 32'd0);
        launch(4'd3, 32'd100, 32'd7);
        cycle();
        cycle();
        cycle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        check("abort_state", {31'd0, busy, hi}, 64'd0);
        for (int i = 0; i < 12; i++) begin
            cycle();
            if (i % 4 == 3) check("abort_no_commit", {hi, lo}, 64'd0);
        end
        check("abort_busy", 64'(busy), 64'd0);
        check("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
